// File: rtl/fixed_pkg.sv
// Shared Q3.12 fixed-point helpers and the backprop FSM state encoding.
package fixed_pkg;

    localparam int unsigned FRAC = 12;
    localparam logic signed [15:0] ONE = 16'sd4096;

    typedef logic signed [15:0] q3_12_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DERIV,
        S_EMIT,
        S_DONE
    } state_t;

    // Clamp a wide signed value into the 16-bit Q3.12 range.
    function automatic q3_12_t sat16(input logic signed [39:0] x);
        if (x > 40'sd32767) begin
            return 16'sd32767;
        end else if (x < -40'sd32768) begin
            return -16'sd32768;
        end else begin
            return q3_12_t'(x);
        end
    endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Q3.12 x Q3.12 signed multiply, floor-shift back to Q3.12, saturate to 16 bits.
module fx_mul_sat
    import fixed_pkg::*;
(
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic signed [15:0] o_y
);

    logic signed [31:0] w_prod;
    logic signed [31:0] w_shift;

    assign w_prod  = i_a * i_b;
    assign w_shift = w_prod >>> FRAC;
    assign o_y     = sat16(40'(w_shift));

endmodule

// File: rtl/layer_backprop.sv
// Backward pass of one fully connected sigmoid layer: streams
// delta_in[j] = (sum_k w[k][j]*delta_out[k]) * a[j]*(1-a[j]) for each input neuron j.
// Optional macro SIGMOID_DERIV_EN: when undefined the derivative stage and the
// activation read are removed and delta_in[j] is the saturated weighted sum.
module layer_backprop
    import fixed_pkg::*;
#(
    parameter int unsigned N_IN  = 784,
    parameter int unsigned N_OUT = 64,
    parameter int unsigned AW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic signed [15:0]         delta_out [N_OUT],
    output logic [AW-1:0]              w_addr,
    input  logic signed [15:0]         w_data,
    output logic [$clog2(N_IN)-1:0]    a_addr,
    input  logic signed [15:0]         a_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(N_IN)-1:0]    out_idx,
    output logic signed [15:0]         out_data,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned JW = $clog2(N_IN);
    localparam int unsigned KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t                r_state;
    logic [JW-1:0]         r_j;
    logic [KW-1:0]         r_k;
    logic signed [39:0]    r_acc;
    logic [AW-1:0]         r_w_addr;
    logic                  r_out_valid;
    logic [JW-1:0]         r_out_idx;
    q3_12_t                r_out_data;
    logic                  r_busy;
    logic                  r_done;

    logic [KW-1:0]         w_pidx;
    logic signed [31:0]    w_prod;
    logic signed [39:0]    w_acc_next;
    logic [JW-1:0]         w_j_next;
    q3_12_t                w_s;
    q3_12_t                w_d;
    q3_12_t                w_scaled;

    // Product of the weight returned this cycle with the delta of the k issued last cycle.
    assign w_pidx     = (r_state == S_DRAIN) ? r_k : r_k - KW'(1);
    assign w_prod     = w_data * delta_out[w_pidx];
    assign w_acc_next = r_acc + 40'(w_prod);
    assign w_j_next   = r_j + JW'(1);

`ifdef SIGMOID_DERIV_EN
    logic [JW-1:0]         r_a_addr;
    q3_12_t                r_a;
    q3_12_t                w_one_minus_a;

    assign w_s           = sat16(r_acc >>> FRAC);
    assign w_one_minus_a = ONE - r_a;
    assign a_addr        = r_a_addr;

    fx_mul_sat u_deriv (
        .i_a (r_a),
        .i_b (w_one_minus_a),
        .o_y (w_d)
    );
`else
    logic w_unused_a;

    // Sum is emitted straight out of DRAIN, so it includes the final product.
    assign w_s        = sat16(w_acc_next >>> FRAC);
    assign w_d        = ONE;
    assign a_addr     = '0;
    assign w_unused_a = ^a_data;
`endif

    fx_mul_sat u_scale (
        .i_a (w_s),
        .i_b (w_d),
        .o_y (w_scaled)
    );

    assign w_addr    = r_w_addr;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;

    // Control FSM with registered outputs and the accumulation datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_j         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_w_addr    <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SIGMOID_DERIV_EN
            r_a_addr    <= '0;
            r_a         <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_j      <= '0;
                        r_k      <= '0;
                        r_acc    <= '0;
                        r_w_addr <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_ACCUM;
`ifdef SIGMOID_DERIV_EN
                        r_a_addr <= '0;
`endif
                    end
                end
                S_ACCUM: begin
                    if (r_k != '0) begin
                        r_acc <= w_acc_next;
                    end
`ifdef SIGMOID_DERIV_EN
                    if (r_k == KW'(1)) begin
                        r_a <= a_data;
                    end
`endif
                    if (r_k == KW'(N_OUT - 1)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_k      <= r_k + KW'(1);
                        r_w_addr <= r_w_addr + AW'(N_IN);
                    end
                end
                S_DRAIN: begin
                    r_acc <= w_acc_next;
`ifdef SIGMOID_DERIV_EN
                    if (N_OUT == 1) begin
                        r_a <= a_data;
                    end
                    r_state <= S_DERIV;
`else
                    r_out_valid <= 1'b1;
                    r_out_idx   <= r_j;
                    r_out_data  <= w_scaled;
                    r_state     <= S_EMIT;
`endif
                end
`ifdef SIGMOID_DERIV_EN
                S_DERIV: begin
                    r_out_valid <= 1'b1;
                    r_out_idx   <= r_j;
                    r_out_data  <= w_scaled;
                    r_state     <= S_EMIT;
                end
`endif
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_j == JW'(N_IN - 1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_j      <= w_j_next;
                            r_k      <= '0;
                            r_acc    <= '0;
                            r_w_addr <= AW'(w_j_next);
`ifdef SIGMOID_DERIV_EN
                            r_a_addr <= w_j_next;
`endif
                            r_state  <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_backprop.sv
// Directed, scoreboard-based bench for layer_backprop (N_IN=2, N_OUT=2).
module tb_layer_backprop;

    localparam int unsigned N_IN  = 2;
    localparam int unsigned N_OUT = 2;
    localparam int unsigned AW    = 16;
`ifdef SIGMOID_DERIV_EN
    localparam int LAT = N_OUT + 3;
`else
    localparam int LAT = N_OUT + 2;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       run;
    logic signed [15:0]         delta_out [N_OUT];
    logic [AW-1:0]              w_addr;
    logic signed [15:0]         w_data;
    logic [$clog2(N_IN)-1:0]    a_addr;
    logic signed [15:0]         a_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [$clog2(N_IN)-1:0]    out_idx;
    logic signed [15:0]         out_data;
    logic                       busy;
    logic                       done;

    logic signed [15:0] wmem [N_IN*N_OUT];
    logic signed [15:0] amem [N_IN];

    typedef struct {
        int idx;
        int data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int fails  = 0;

    layer_backprop #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .delta_out (delta_out),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency weight and activation memories.
    always @(posedge clk) begin
        w_data <= wmem[int'(w_addr) % (N_IN*N_OUT)];
        a_data <= amem[a_addr];
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int model(input int j);
        longint sum;
        longint s;
        longint y;
`ifdef SIGMOID_DERIV_EN
        longint a;
        longint d;
`endif
        sum = 0;
        for (int k = 0; k < N_OUT; k++) begin
            sum += longint'(wmem[k*N_IN + j]) * longint'(delta_out[k]);
        end
        s = sat(sum >>> 12);
`ifdef SIGMOID_DERIV_EN
        a = longint'(amem[j]);
        d = (a * (4096 - a)) >>> 12;
        y = sat((s * d) >>> 12);
`else
        y = s;
`endif
        return int'(y);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full run from C0; optional backpressure on one word and an extra run pulse while busy.
    task automatic do_run(input int bp_word, input int bp_len, input bit extra_run);
        int n;
        int words;
        int stall;
        int last_acc;
        bit first_seen;
        bit got_done;
        exp_t e;
        logic signed [63:0] h_idx;
        logic signed [63:0] h_data;
        logic signed [63:0] h_wa;
        for (int j = 0; j < N_IN; j++) sb.push_back('{j, model(j)});
        words = 0; stall = 0; last_acc = 0; first_seen = 0; got_done = 0;
        h_idx = 0; h_data = 0; h_wa = 0;
        run = 1'b1;
        out_ready = 1'b1;
        step();
        run = 1'b0;
        n = 1;
        chk("busy_after_run", busy, 1);
        while (!got_done && n < 200) begin
            if (extra_run) run = (n == 2);
            if (out_valid) begin
                if (!first_seen) begin
                    first_seen = 1;
                    chk("first_valid_latency", n, LAT);
                end
                if (words == bp_word && stall < bp_len) begin
                    if (stall == 0) begin
                        h_idx = out_idx; h_data = out_data; h_wa = w_addr;
                    end else begin
                        chk("hold_idx", out_idx, h_idx);
                        chk("hold_data", out_data, h_data);
                        chk("hold_w_addr", w_addr, h_wa);
                    end
                    stall++;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("out_idx", out_idx, e.idx);
                        chk("out_data", out_data, e.data);
                    end else begin
                        chk("scoreboard_depth", sb.size(), 1);
                    end
`ifndef SIGMOID_DERIV_EN
                    chk("a_addr_tied", a_addr, 0);
`endif
                    words++;
                    last_acc = n;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done) begin
                got_done = 1;
                chk("done_after_last_accept", n, last_acc + 1);
                chk("done_cycle", n, N_IN*LAT + bp_len + 1);
                chk("words_emitted", words, N_IN);
                chk("busy_in_done", busy, 1);
            end
            step();
            n++;
        end
        run = 1'b0;
        chk("done_seen", got_done, 1);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        run = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 16'sd4096;
        delta_out[0] = 16'sd2048;
        delta_out[1] = 16'sd1024;
        amem[0] = 16'sd2048;
        amem[1] = 16'sd2048;
        repeat (3) step();

        // Reset state
        chk("rst_w_addr", w_addr, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        step();

        // Basic: sum 3072, derivative 1024 -> 768 (3072 without derivative)
`ifdef SIGMOID_DERIV_EN
        chk("basic_model", model(0), 768);
`else
        chk("basic_model", model(0), 3072);
`endif
        do_run(-1, 0, 1'b0);
        step();

        // Saturation of the weighted sum
        for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 16'sd28672;
        delta_out[0] = 16'sd28672;
        delta_out[1] = 16'sd28672;
`ifdef SIGMOID_DERIV_EN
        chk("sat_model", model(1), 8191);
`else
        chk("sat_model", model(1), 32767);
`endif
        do_run(-1, 0, 1'b0);
        step();

        // Mixed signs with backpressure on the second word
        wmem[0] = 16'sd4096;  wmem[1] = -16'sd8192;
        wmem[2] = 16'sd2048;  wmem[3] = 16'sd12288;
        delta_out[0] = -16'sd3000;
        delta_out[1] = 16'sd1500;
        amem[0] = 16'sd1000;
        amem[1] = 16'sd3500;
        do_run(1, 5, 1'b0);
        step();

        // Extra run pulse while busy must be ignored
        for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 16'sd4096;
        delta_out[0] = 16'sd2048;
        delta_out[1] = 16'sd1024;
        amem[0] = 16'sd2048;
        amem[1] = 16'sd2048;
        do_run(-1, 0, 1'b1);
        step();

        // Reset during ACCUM of j=1
        run = 1'b1;
        out_ready = 1'b1;
        step();
        run = 1'b0;
        n = 1;
        while (n < LAT + 1) begin
            step();
            n++;
        end
        chk("mid_w_addr_j1", w_addr, 1);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_w_addr", w_addr, 0);
        chk("mid_rst_a_addr", a_addr, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_idx", out_idx, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_done_after_rst", done, 0);
        end
        do_run(-1, 0, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
